ram_fifo_ctrl: RTL and testbench

//   Single-clock synchronous FIFO built around one dual_port_ram instance:

---
 rtl/pkg_fifo.sv | 13 +
 rtl/dual_port_ram.sv | 33 +++
 rtl/ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pkg_fifo.sv
// Shared FIFO sizing constants and the occupancy type used by ram_fifo_ctrl.
package pkg_fifo;

    localparam int unsigned FIFO_ADDR_WIDTH = 4;
    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned DEPTH           = 2 ** FIFO_ADDR_WIDTH;

    typedef logic [FIFO_ADDR_WIDTH:0] fifo_count_t;

    localparam fifo_count_t FIFO_EMPTY = fifo_count_t'(0);
    localparam fifo_count_t FIFO_FULL  = fifo_count_t'(DEPTH);

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module dual_port_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rclk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned N_WORDS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [N_WORDS];

    always_ff @(posedge wclk) begin
        if (write_en) begin
            mem[waddr] <= din;
        end
    end

    // Read data only updates on an enabled read so dout holds between pops.
    always_ff @(posedge rclk) begin
        if (read_en) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock non-show-ahead FIFO controller sequencing one dual_port_ram;
// tracks pointers, occupancy, registered status flags and error pulses.
module ram_fifo_ctrl
    import pkg_fifo::*;
#(
    parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int unsigned ALMOST_FULL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam int unsigned N_ENTRIES = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH:0]   count_nxt;

    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    // A flush or reset must not disturb RAM contents or the read register.
    assign ram_we = push_ok & ~sync_reset & ~reset;
    assign ram_re = pop_ok & ~sync_reset & ~reset;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    // Flags are registered from the next-state count so they track count exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            dout_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (sync_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            dout_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count       <= count_nxt;
            full        <= (count_nxt == CW'(N_ENTRIES));
            empty       <= (count_nxt == CW'(0));
            almost_full <= (count_nxt >= CW'(ALMOST_FULL));
            dout_valid  <= pop_ok;
            overflow    <= wr_en & full;
            underflow   <= rd_en & empty;
        end
    end

    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .wclk     (clk),
        .write_en (ram_we),
        .waddr    (wr_ptr),
        .din      (din),
        .rclk     (clk),
        .read_en  (ram_re),
        .raddr    (rd_ptr),
        .dout     (dout)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl with default parameters.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       sync_reset;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    ram_fifo_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sync_reset  (sync_reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic sr);
        @(negedge clk);
        wr_en      = w;
        rd_en      = r;
        din        = d;
        sync_reset = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        sync_reset = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        din        = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1. reset then idle
        for (int i = 0; i < 10; i++) begin
            idle();
            check("idle_empty", 32'(empty), 32'd1);
            check("idle_full", 32'(full), 32'd0);
            check("idle_count", 32'(count), 32'd0);
            check("idle_dv", 32'(dout_valid), 32'd0);
        end

        // 2. fill to full, then one dropped push
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
            check("fill_ovf", 32'(overflow), 32'd0);
        end
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        idle();
        check("ovf_clear", 32'(overflow), 32'd0);

        // 3. drain in order, then one ignored pop
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check("drain_dv", 32'(dout_valid), 32'd1);
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_count", 32'(count), 32'(16 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_dv", 32'(dout_valid), 32'd0);
        idle();
        check("udf_clear", 32'(underflow), 32'd0);

        // 4. wrap-around with a simultaneous push/pop phase
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check("wrap_a_dout", 32'(dout), 32'(8'h20 + i));
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        check("wrap_pre_count", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
            check("sim_dv", 32'(dout_valid), 32'd1);
            check("sim_dout", 32'(dout), 32'(8'h40 + i));
            check("sim_count", 32'(count), 32'd12);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check("wrap_b_dout", 32'(dout), 32'(8'h60 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // 5. simultaneous on empty and on full
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        check("e_sim_count", 32'(count), 32'd1);
        check("e_sim_udf", 32'(underflow), 32'd1);
        check("e_sim_dv", 32'(dout_valid), 32'd0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("e_sim_dout", 32'(dout), 32'hAA);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        check("f_pre_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0);
        check("f_sim_count", 32'(count), 32'd15);
        check("f_sim_ovf", 32'(overflow), 32'd1);
        check("f_sim_dv", 32'(dout_valid), 32'd1);
        check("f_sim_dout", 32'(dout), 32'h80);
        check("f_sim_full", 32'(full), 32'd0);

        // 6a. flush beats a push in the same cycle
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("flush0_count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        check("flush_pre", 32'(count), 32'd5);
        cycle(1'b1, 1'b0, 8'h99, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        idle();
        check("flush_hold", 32'(count), 32'd0);
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_flush_dout", 32'(dout), 32'h55);

        // 6b. async reset mid-burst takes effect between edges
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'hD3, 1'b0);
        check("burst_dv", 32'(dout_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_dv", 32'(dout_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        idle();
        check("arst_after", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
